seven_seg_display: RTL and testbench

Multi-digit active-low 7-segment display driver. Accepts a binary value, converts it to per-digit BCD with a sequential double-dabble engine (one shift per clock), or splits it into hex nibbles in hex mode. Registers the glyphs for all digits, with leading-zero blanking and overflow indication. Sits between datapath/score counters and the board HEX displays.

---
 rtl/seven_seg_display.sv | 186 ++++++++++++++++++
 tb/tb_seven_seg_display.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seven_seg_display                                            |
// | Description : Multi-digit active-low 7-segment driver with sequential      |
// |               double-dabble BCD conversion, hex mode, leading-zero         |
// |               blanking and overflow dashes.                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module seven_seg_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int BIN_WIDTH     = 14,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    load,
  input  logic                    hex_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] segments
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [6:0]  DASH    = 7'b0111111;
  localparam logic [6:0]  BLANK   = 7'b1111111;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BIN_WIDTH-1:0]    shift_q, shift_d;
  logic [DW-1:0]           digits_q, digits_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ovf_pend_q, ovf_pend_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

  logic [63:0]             value_ext;
  logic                    dec_ovf;
  logic                    hex_ovf;
  logic [DW-1:0]           adj;
  logic [7*NUM_DIGITS-1:0] seg_next;

  assign value_ext = 64'(value);
  assign dec_ovf   = value_ext > DEC_MAX;
  assign hex_ovf   = (value_ext >> DW) != 64'd0;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      else                            adj[4*i +: 4] = digits_q[4*i +: 4];
    end
  end

  // Walk from the top digit down; blanking stops at the first nonzero digit.
  always_comb begin
    logic       leading;
    logic [3:0] nib;
    seg_next = '1;
    leading  = 1'b1;
    nib      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = digits_q[4*i +: 4];
      if (ovf_pend_q) begin
        seg_next[7*i +: 7] = DASH;
      end else if ((BLANK_LEADING != 0) && leading && (nib == 4'd0) && (i != 0)) begin
        seg_next[7*i +: 7] = BLANK;
      end else begin
        leading            = 1'b0;
        seg_next[7*i +: 7] = glyph(nib);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    digits_d   = digits_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    seg_d      = seg_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          ovf_pend_d = hex_mode ? hex_ovf : dec_ovf;
          if (!hex_mode && !dec_ovf) begin
            state_d  = CONVERT;
            shift_d  = value;
            digits_d = '0;
            cnt_d    = '0;
          end else begin
            state_d  = COMMIT;
            digits_d = value_ext[DW-1:0];
          end
        end
      end
      CONVERT: begin
        digits_d = {adj[DW-2:0], shift_q[BIN_WIDTH-1]};
        shift_d  = shift_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        seg_d      = seg_next;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CONVERT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      digits_q   <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      seg_q      <= '1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      digits_q   <= digits_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign segments = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seven_seg_display                                         |
// | Description : Directed scoreboard bench for seven_seg_display.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_seven_seg_display;

  localparam int ND = 4;
  localparam int BW = 14;

  typedef struct {
    logic [7*ND-1:0] seg;
    logic            ovf;
    int              cyc;
    string           tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [BW-1:0]   value = '0;
  logic            load = 1'b0;
  logic            hex_mode = 1'b0;
  logic            busy, done, overflow;
  logic [7*ND-1:0] segments;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  seven_seg_display #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .BLANK_LEADING(1)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
    .busy(busy), .done(done), .overflow(overflow), .segments(segments)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] gl(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Reference: arithmetic digit extraction, independent of the shift engine.
  function automatic exp_t model(input int unsigned v, input bit hex, input int e0, input string tag);
    exp_t e;
    int   d[ND];
    int   p;
    bit   lead;
    e.ovf = hex ? ((v >> (4*ND)) != 0) : (v > 9999);
    p = 1;
    for (int i = 0; i < ND; i++) begin
      d[i] = hex ? int'((v >> (4*i)) & 15) : int'((v / p) % 10);
      p = p * 10;
    end
    lead = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      if (e.ovf) e.seg[7*i +: 7] = 7'b0111111;
      else if (lead && d[i] == 0 && i != 0) e.seg[7*i +: 7] = 7'b1111111;
      else begin
        lead = 1'b0;
        e.seg[7*i +: 7] = gl(d[i]);
      end
    end
    e.cyc = e0 + ((hex || e.ovf) ? 1 : BW + 1);
    e.tag = tag;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_seg"}, 64'(segments), 64'(e.seg));
        chk({e.tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
        chk({e.tag, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
        chk({e.tag, "_busy_at_done"}, 64'(busy), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int unsigned v, input bit hex, input string tag);
    value    = BW'(v);
    hex_mode = hex;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    sb.push_back(model(v, hex, cyc, tag));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    int nb;
    tick(); tick();
    chk("reset_seg", 64'(segments), {36'd0, {7*ND{1'b1}}});
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    #2 reset = 1'b0;
    tick();

    // Decimal 1234: busy must span exactly BW cycles
    issue(1234, 1'b0, "dec1234");
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      tick();
    end
    chk("dec1234_busy_cycles", 64'(nb), 64'(BW));
    wait_idle("dec1234");

    // Reset in the middle of a conversion, segments currently non-blank
    value = BW'(1234); hex_mode = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("midreset_seg", 64'(segments), {36'd0, {7*ND{1'b1}}});
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_ovf", 64'(overflow), 64'd0);
    tick();
    #2 reset = 1'b0;
    repeat (25) tick();

    issue(7, 1'b0, "dec7");       wait_idle("dec7");
    issue(0, 1'b0, "dec0");       wait_idle("dec0");
    issue(9999, 1'b0, "dec9999"); wait_idle("dec9999");

    issue(10000, 1'b0, "dec10000");
    chk("ovf_busy_low", 64'(busy), 64'd0);
    wait_idle("dec10000");
    issue(42, 1'b0, "dec42");     wait_idle("dec42");

    issue(32'h2AF, 1'b1, "hex2af"); wait_idle("hex2af");
    issue(32'hF00, 1'b1, "hexf00"); wait_idle("hexf00");

    // A second load during the conversion must be dropped
    issue(5678, 1'b0, "dec5678");
    repeat (3) tick();
    value = BW'(1111); load = 1'b1;
    tick();
    load = 1'b0;
    wait_idle("dec5678");

    // Back-to-back with load held high: 100 is accepted in the done cycle of 99
    value = BW'(99); hex_mode = 1'b0; load = 1'b1;
    tick();
    sb.push_back(model(99, 1'b0, cyc, "b2b99"));
    value = BW'(100);
    repeat (BW + 1) tick();
    tick();
    load = 1'b0;
    sb.push_back(model(100, 1'b0, cyc, "b2b100"));
    wait_idle("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
